fetch_unit: RTL

- Instruction fetch front-end for the RV32I core; the producer side of the control unit's PCSrc/Instr interface.
- Holds the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their PCs and presents them to decode/control with a valid/ready handshake.
- Applies the PCSrc redirect (branch/jal/jalr) when an instruction retires, flushing wrong-path fetches.

---
 rtl/rv_pkg.sv | 33 +++
 rtl/fetch_unit_if.sv | 18 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_pkg : shared RV32I front-end types, PCSrc encodings and helpers   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_TARGET = 2'b01,
        PCSRC_ALU    = 2'b10
    } pcsrc_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Both 10 and 11 select the jalr path; bit0 of the ALU result is cleared.
    function automatic logic [XLEN-1:0] redirect_target(
        input logic [1:0]      src,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] imm,
        input logic [XLEN-1:0] alu
    );
        return (src == PCSRC_TARGET) ? pc + imm : (alu & {{(XLEN-1){1'b1}}, 1'b0});
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_if : instruction-memory req/gnt/rvalid read channel       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_unit_if;
    import rv_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [ILEN-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo : synchronous {pc, instr} buffer, flush beats push        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == (c_aw+1)'(DEPTH));
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (c_aw+1)'(w_push) - (c_aw+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit : RV32I fetch front-end with credit-limited issue/redirect|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_unit_if.master        imem,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [ILEN-1:0]     Instr,
    output logic [XLEN-1:0]     PC,
    output logic [XLEN-1:0]     PCPlus4,
    input  logic [1:0]          PCSrc,
    input  logic [XLEN-1:0]     ImmExt,
    input  logic [XLEN-1:0]     ALUResult,
    output logic                misalign_err
);
    localparam int                c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w:0]  c_depth = (c_cnt_w+1)'(FIFO_DEPTH);

    logic                r_run;
    logic                r_misalign;
    logic [XLEN-1:0]     r_fetch_pc;
    logic [XLEN-1:0]     r_resp_pc;
    logic [c_cnt_w-1:0]  r_outstanding;
    logic [c_cnt_w-1:0]  r_drop_cnt;

    logic                w_grant;
    logic                w_resp;
    logic                w_drop;
    logic                w_push;
    logic                w_retire;
    logic                w_redirect;
    logic [XLEN-1:0]     w_target;
    logic [c_cnt_w-1:0]  w_out_next;
    logic [c_cnt_w-1:0]  w_count;
    logic [c_cnt_w:0]    w_credit_used;
    logic                w_empty;
    logic                w_full;
    fetch_entry_t        w_push_entry;
    fetch_entry_t        w_head;

    // Request is a function of registers only; r_run keeps it low in reset.
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_count};
    assign imem.req      = r_run && !r_misalign && (w_credit_used < c_depth);
    assign imem.addr     = r_fetch_pc;

    assign w_grant    = imem.req && imem.gnt;
    assign w_resp     = imem.rvalid && (r_outstanding != '0);
    assign w_drop     = w_resp && (r_drop_cnt != '0);
    assign w_push     = w_resp && !w_drop && !r_misalign;
    assign w_retire   = instr_valid && instr_ready;
    assign w_redirect = w_retire && (PCSrc != PCSRC_PLUS4);
    assign w_target   = redirect_target(PCSrc, PC, ImmExt, ALUResult);
    assign w_out_next = r_outstanding + c_cnt_w'(w_grant) - c_cnt_w'(w_resp);

    assign w_push_entry = '{pc: r_resp_pc, instr: imem.rdata};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_push_entry),
        .pop   (w_retire),
        .flush (w_redirect),
        .dout  (w_head),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    assign instr_valid  = !w_empty;
    assign Instr        = w_head.instr;
    assign PC           = w_head.pc;
    assign PCPlus4      = w_head.pc + 32'd4;
    assign misalign_err = r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_misalign    <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= w_out_next;
            if (w_redirect) begin
                // Everything still in flight, including this cycle's grant, is wrong-path.
                r_drop_cnt <= w_out_next;
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                if (w_target[1]) r_misalign <= 1'b1;
            end else begin
                if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_drop)  r_drop_cnt <= r_drop_cnt - 1'b1;
                if (w_push)  r_resp_pc  <= r_resp_pc + 32'd4;
            end
        end
    end

    logic w_unused;
    assign w_unused = w_full;
endmodule
`default_nettype wire
